// File: rtl/hex_msg_pkg.sv
// Shared definitions for the HELLO message display path.
// Holds the character codes, the active-low 7-segment patterns ({g,f,e,d,c,b,a})
// and the rotator state encoding.
package hex_msg_pkg;

   localparam int CH_BLANK = 0;
   localparam int CH_H     = 1;
   localparam int CH_E     = 2;
   localparam int CH_L     = 3;
   localparam int CH_O     = 4;

   localparam logic [6:0] SEG_H     = 7'b0001001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_O     = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      LOAD   = 2'b01,
      ROTATE = 2'b10
   } state_t;

endpackage

// File: rtl/hex_char_decoder.sv
// Character code to active-low 7-segment pattern, purely combinational.
// Ports:
//   char_code  in   CHAR_W  character code (0 blank, 1 H, 2 E, 3 L, 4 O, others blank)
//   seg        out  7       segments {g,f,e,d,c,b,a}, active-low
module hex_char_decoder
   import hex_msg_pkg::*;
#(
   parameter int CHAR_W = 3
) (
   input  logic [CHAR_W-1:0] char_code,
   output logic [6:0]        seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (char_code == CHAR_W'(CH_H)) begin
         seg = SEG_H;
      end else if (char_code == CHAR_W'(CH_E)) begin
         seg = SEG_E;
      end else if (char_code == CHAR_W'(CH_L)) begin
         seg = SEG_L;
      end else if (char_code == CHAR_W'(CH_O)) begin
         seg = SEG_O;
      end
   end

endmodule

// File: rtl/hex_message_rotator.sv
// Display-side consumer of the HELLO sequencer's Shift/state stream.
// Characters are shifted in one per cycle on Load; while Shift is held the
// message rotates circularly left once every TICK_DIV cycles. Every digit is
// decoded to an active-low 7-segment pattern.
// Ports:
//   Clock     in   1             system clock, rising edge
//   Reset     in   1             asynchronous, active-low reset
//   Load      in   1             CharIn valid; shift it into digit 0 (beats Shift)
//   CharIn    in   CHAR_W        character code
//   Shift     in   1             rotate enable, level-sensitive
//   HexOut    out  7*NUM_DIGITS  HexOut[7*i +: 7] = digit i segments, active-low
//   Rotating  out  1             high while in ROTATE
//
// state  | meaning
// IDLE   | contents held, tick counter held at 0
// LOAD   | a character was shifted in on the last cycle
// ROTATE | tick counter running, circular left step at terminal count
module hex_message_rotator
   import hex_msg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int TICK_DIV   = 50_000_000,
   parameter int CHAR_W     = 3
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    Load,
   input  logic [CHAR_W-1:0]       CharIn,
   input  logic                    Shift,
   output logic [7*NUM_DIGITS-1:0] HexOut,
   output logic                    Rotating
);

   localparam int               CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TICK_DIV - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  tick_cnt;
   logic [CHAR_W-1:0] digit [NUM_DIGITS];
   logic              do_load, do_rot, cnt_run;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      do_load   = 1'b0;
      do_rot    = 1'b0;
      cnt_run   = 1'b0;
      if (Load) begin
         state_nxt = LOAD;
         do_load   = 1'b1;
      end else begin
         case (state)
            IDLE, LOAD: state_nxt = Shift ? ROTATE : IDLE;
            ROTATE: begin
               if (Shift) begin
                  state_nxt = ROTATE;
                  cnt_run   = 1'b1;
                  do_rot    = (tick_cnt == CNT_TC);
               end else begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Cleared whenever not counting, so a re-entry into ROTATE always waits a
   // full TICK_DIV cycles; with TICK_DIV==1 the compare is true every cycle.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         tick_cnt <= '0;
      end else if (!cnt_run || do_rot) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit[i] <= CHAR_W'(CH_BLANK);
         end
      end else if (do_load || do_rot) begin
         for (int i = 1; i < NUM_DIGITS; i++) begin
            digit[i] <= digit[i-1];
         end
         digit[0] <= do_load ? CharIn : digit[NUM_DIGITS-1];
      end
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
      hex_char_decoder #(
         .CHAR_W(CHAR_W)
      ) u_dec (
         .char_code(digit[i]),
         .seg      (HexOut[7*i +: 7])
      );
   end

   assign Rotating = (state == ROTATE);

endmodule
